// File: rtl/assign_seq_ctrl.sv
// Frame controller for the N x N minimum-cost assignment datapath: captures the cost
// matrix, starts and times the solver, re-checks its answer and streams the result.
module assign_seq_ctrl #(
    parameter int N       = 8,
    parameter int COST_W  = 7,
    parameter int SUM_W   = 10,
    parameter int TIMEOUT = 65535,
    localparam int IW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [COST_W-1:0] in_cost,
    output logic              core_start,
    input  logic              core_done,
    input  logic [SUM_W-1:0]  core_cost,
    input  logic [N*IW-1:0]   core_job,
    input  logic [IW-1:0]     rd_row,
    input  logic [IW-1:0]     rd_col,
    output logic [COST_W-1:0] rd_cost,
    output logic              out_valid,
    output logic [IW:0]       out_job,
    output logic [SUM_W-1:0]  out_cost,
    output logic              err
);

    localparam int CW = 2 * IW;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, SOLVE, CHECK, OUTPUT} state_t;

    state_t            state;
    logic [COST_W-1:0] mem [N*N];
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_n;
    logic [N*IW-1:0]   job_q;
    logic [SUM_W-1:0]  cost_q;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_n;
    logic [N-1:0]      used;
    logic [IW-1:0]     widx;
    logic [IW-1:0]     widx_inc;
    logic              timed_out;
    logic              we;
    logic [CW-1:0]     waddr;
    logic [IW-1:0]     chk_job;
    logic [IW-1:0]     nxt_job;
    logic [COST_W-1:0] chk_entry;

    always_comb begin
        we        = in_valid && !rst && (state == IDLE || state == LOAD);
        waddr     = (state == LOAD) ? cnt : '0;
        widx_inc  = widx + 1'b1;
        chk_job   = job_q[widx*IW +: IW];
        nxt_job   = job_q[widx_inc*IW +: IW];
        chk_entry = mem[{widx, chk_job}];
        sum_n     = sum + SUM_W'(chk_entry);
        timer_n   = timer + 1'b1;
        rd_cost   = mem[{rd_row, rd_col}];
    end

    // Buffer is deliberately left out of reset so a frame can be re-read after rst.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= in_cost;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            timer      <= '0;
            widx       <= '0;
            sum        <= '0;
            used       <= '0;
            job_q      <= '0;
            cost_q     <= '0;
            timed_out  <= 1'b0;
            core_start <= 1'b0;
            out_valid  <= 1'b0;
            out_job    <= '0;
            out_cost   <= '0;
            err        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        err   <= 1'b0;
                        cnt   <= CW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1)
                            state <= START;
                    end
                end
                START: begin
                    core_start <= 1'b1;
                    timer      <= '0;
                    state      <= SOLVE;
                end
                SOLVE: begin
                    timer <= timer_n;
                    widx  <= '0;
                    sum   <= '0;
                    used  <= '0;
                    if (core_done) begin
                        job_q     <= core_job;
                        cost_q    <= core_cost;
                        timed_out <= 1'b0;
                        state     <= CHECK;
                    end else if (timer_n == TW'(TIMEOUT)) begin
                        // Hung solver skips CHECK and goes straight to a zeroed result stream.
                        err       <= 1'b1;
                        job_q     <= '0;
                        cost_q    <= '0;
                        timed_out <= 1'b1;
                        out_valid <= 1'b1;
                        out_job   <= '0;
                        out_cost  <= '0;
                        state     <= OUTPUT;
                    end
                end
                CHECK: begin
                    sum           <= sum_n;
                    used[chk_job] <= 1'b1;
                    widx          <= widx_inc;
                    if (used[chk_job])
                        err <= 1'b1;
                    if (widx == '1) begin
                        if (sum_n != cost_q)
                            err <= 1'b1;
                        out_valid <= 1'b1;
                        out_job   <= (IW+1)'(job_q[IW-1:0]) + 1'b1;
                        out_cost  <= cost_q;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (widx == '1) begin
                        widx      <= '0;
                        out_valid <= 1'b0;
                        out_job   <= '0;
                        out_cost  <= '0;
                        state     <= IDLE;
                    end else begin
                        widx    <= widx_inc;
                        out_job <= timed_out ? '0 : (IW+1)'(nxt_job) + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assign_seq_ctrl.sv
// Scoreboard bench for assign_seq_ctrl: stimulus pushes expected result beats,
// a negedge monitor pops and compares them whenever out_valid is presented.
module tb_assign_seq_ctrl;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [6:0]  in_cost;
    logic        core_start;
    logic        core_done;
    logic [9:0]  core_cost;
    logic [23:0] core_job;
    logic [2:0]  rd_row;
    logic [2:0]  rd_col;
    logic [6:0]  rd_cost;
    logic        out_valid;
    logic [3:0]  out_job;
    logic [9:0]  out_cost;
    logic        err;

    typedef struct {
        int unsigned edge_no;
        logic [3:0]  job;
        logic [9:0]  cost;
        logic        err;
    } beat_t;

    beat_t       sb[$];
    beat_t       mb;
    logic [6:0]  mat [64];
    int unsigned cyc = 0;
    int unsigned last_start = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    assign_seq_ctrl #(.N(8), .COST_W(7), .SUM_W(10), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cost(in_cost),
        .core_start(core_start), .core_done(core_done), .core_cost(core_cost),
        .core_job(core_job), .rd_row(rd_row), .rd_col(rd_col), .rd_cost(rd_cost),
        .out_valid(out_valid), .out_job(out_job), .out_cost(out_cost), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", int'(out_valid), 0);
                end else begin
                    mb = sb.pop_front();
                    check("beat_edge", int'(cyc + 1), int'(mb.edge_no));
                    check("out_job", out_job, mb.job);
                    check("out_cost", out_cost, mb.cost);
                    check("beat_err", err, mb.err);
                end
            end else begin
                check("idle_out_job", out_job, 0);
                check("idle_out_cost", out_cost, 0);
            end
        end
    end

    function automatic logic [23:0] pack_jobs(input int kind);
        logic [23:0] j = '0;
        for (int w = 0; w < 8; w++) begin
            case (kind)
                0:       j[3*w +: 3] = 3'(w);
                1:       j[3*w +: 3] = 3'(7 - w);
                default: j[3*w +: 3] = 3'd0;
            endcase
        end
        return j;
    endfunction

    task automatic fill_diag();
        for (int k = 0; k < 64; k++) mat[k] = (k / 8 == k % 8) ? 7'd1 : 7'd50;
    endtask

    task automatic load_frame(input bit gaps, output int unsigned last_edge);
        last_edge = 0;
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1;
            in_cost  = mat[k];
            @(negedge clk);
            if (k == 0) check("err_cleared_on_first_sample", err, 0);
            in_valid = 1'b0;
            if (k == 63) last_edge = cyc;
            else if (gaps) @(negedge clk);
        end
    endtask

    task automatic wait_start(input int unsigned last_edge);
        int n = 0;
        while (!core_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("core_start_seen", core_start, 1);
        check("core_start_edge", int'(cyc), int'(last_edge + 1));
        last_start = cyc;
        @(negedge clk);
        check("core_start_one_cycle", core_start, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic finish_done(input logic [23:0] jobs, input logic [9:0] cost,
                               input logic exp_err, input int delay, input bit junk);
        int unsigned t;
        beat_t       b;
        logic [2:0]  jw;
        repeat (delay) begin
            if (junk) begin
                in_valid = 1'b1;
                in_cost  = 7'h55;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        core_done = 1'b1;
        core_job  = jobs;
        core_cost = cost;
        t = cyc + 1;
        for (int w = 0; w < 8; w++) begin
            jw        = jobs[3*w +: 3];
            b.edge_no = t + 9 + w;
            b.job     = 4'(jw) + 4'd1;
            b.cost    = cost;
            b.err     = exp_err;
            sb.push_back(b);
        end
        @(negedge clk);
        core_done = 1'b0;
        wait_drain();
    endtask

    task automatic run_frame(input logic [23:0] jobs, input logic [9:0] cost, input logic exp_err);
        int unsigned le;
        load_frame(1'b0, le);
        wait_start(le);
        finish_done(jobs, cost, exp_err, 4, 1'b0);
        check("err_sticky_after_frame", err, exp_err);
    endtask

    initial begin
        int unsigned le;
        beat_t       b;
        rst = 1'b1; in_valid = 1'b0; in_cost = '0; core_done = 1'b0;
        core_cost = '0; core_job = '0; rd_row = '0; rd_col = '0;
        repeat (3) @(negedge clk);
        check("rst_core_start", core_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_job", out_job, 0);
        check("rst_out_cost", out_cost, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        fill_diag();
        run_frame(pack_jobs(0), 10'd8, 1'b0);
        run_frame(pack_jobs(0), 10'd9, 1'b1);
        run_frame(pack_jobs(2), 10'd351, 1'b1);

        // Gapped load of k, reads during SOLVE, junk in_valid while solving
        for (int k = 0; k < 64; k++) mat[k] = 7'(k);
        load_frame(1'b1, le);
        wait_start(le);
        rd_row = 3'd7; rd_col = 3'd7; #1;
        check("rd_cost_7_7", rd_cost, 63);
        rd_row = 3'd2; rd_col = 3'd5; #1;
        check("rd_cost_2_5", rd_cost, 21);
        finish_done(pack_jobs(0), 10'd252, 1'b0, 4, 1'b1);
        for (int k = 0; k < 64; k++) begin
            rd_row = 3'(k / 8); rd_col = 3'(k % 8); #1;
            check("buffer_unchanged", rd_cost, k);
        end

        // Solver hang
        fill_diag();
        load_frame(1'b0, le);
        wait_start(le);
        for (int w = 0; w < 8; w++) begin
            b.edge_no = last_start + 101 + w;
            b.job = '0; b.cost = '0; b.err = 1'b1;
            sb.push_back(b);
        end
        while (cyc < last_start + 99) @(negedge clk);
        check("err_before_timeout", err, 0);
        @(negedge clk);
        check("err_at_timeout", err, 1);
        wait_drain();

        for (int k = 0; k < 64; k++) mat[k] = 7'd127;
        run_frame(pack_jobs(1), 10'd1016, 1'b0);

        // Reset while solving, then a stray core_done in IDLE must produce nothing
        fill_diag();
        load_frame(1'b0, le);
        wait_start(le);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midsolve_rst_core_start", core_start, 0);
        check("midsolve_rst_out_valid", out_valid, 0);
        check("midsolve_rst_err", err, 0);
        rst = 1'b0;
        core_done = 1'b1; core_job = pack_jobs(0); core_cost = 10'd8;
        @(negedge clk);
        core_done = 1'b0;
        repeat (20) @(negedge clk);
        run_frame(pack_jobs(0), 10'd8, 1'b0);

        check("final_scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/assign_seq_ctrl.md
Name: assign_seq_ctrl

Overview:
- Frame controller for the 8-worker x 8-job minimum-cost assignment datapath.
- Captures the serial 64-entry cost matrix into a local buffer and serves it to the solver core through a read port.
- Starts the solver core and waits for it, with a watchdog timeout.
- Independently re-checks the returned assignment, then serialises the result onto the out_valid/out_job/out_cost output stream.

Parameters:
- N, 8, number of workers and number of jobs (matrix is N x N).
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of the total cost (max total 8*127 = 1016).
- TIMEOUT, 65535, maximum number of SOLVE cycles before the solver is declared hung.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  cost sample valid.
- in_cost  in  7  cost sample, row-major: worker 0 jobs 0..7, then worker 1, and so on.
- core_start  out  1  one-cycle start pulse to the solver core.
- core_done  in  1  solver result valid, sampled only in SOLVE.
- core_cost  in  10  solver's reported minimum total cost.
- core_job  in  24  packed assignment: bits [3w+2:3w] = job index 0..7 of worker w.
- rd_row  in  3  solver read address, worker.
- rd_col  in  3  solver read address, job.
- rd_cost  out  7  combinational read of buf[rd_row][rd_col].
- out_valid  out  1  result stream valid.
- out_job  out  4  job number 1..8 of the current worker.
- out_cost  out  10  total cost.
- err  out  1  frame error flag (check mismatch, non-permutation, or timeout).

Behaviour:
- Reset (rst high at posedge):
  - state = IDLE; load count, timer and check counters cleared.
  - core_start = 0, out_valid = 0, out_job = 0, out_cost = 0, err = 0.
  - Buffer contents are not cleared. Reset overrides every state, including mid-LOAD, mid-SOLVE and mid-OUTPUT.
- IDLE:
  - in_valid high stores in_cost at index 0, clears err, and moves to LOAD with cnt = 1.
- LOAD:
  - Each posedge with in_valid high stores in_cost at buf[cnt[5:3]][cnt[2:0]], then cnt++.
  - Gaps (in_valid low) are allowed; cnt holds during a gap.
  - After the 64th store, move to START.
- START:
  - Drive core_start = 1 for exactly one cycle, clear the timer, move to SOLVE.
- SOLVE:
  - Timer increments every cycle.
  - If core_done is high: capture core_job and core_cost, go to CHECK.
  - Else if timer reaches TIMEOUT: set err, force the captured jobs to 0 and the captured cost to 0, go to OUTPUT directly.
  - If core_done and timeout occur in the same cycle, core_done wins.
- CHECK (8 cycles, w = 0..7):
  - Accumulate sum += buf[w][job[w]] using a 10-bit unsigned sum, no overflow possible.
  - Set bit job[w] of an 8-bit used mask; if the bit is already set, set err (duplicate job).
  - After w = 7: if sum != captured core_cost, set err. Then go to OUTPUT.
- OUTPUT (8 cycles, w = 0..7):
  - out_valid = 1, out_job = job[w] + 1, out_cost = captured core_cost (held constant all 8 cycles).
  - On timeout, out_job = 0 and out_cost = 0.
  - After the 8th cycle, return to IDLE.
- out_job and out_cost are 0 whenever out_valid is 0.
- err stays high from the moment it is set until the first in_valid of the next frame or rst.
- Latency: core_done sampled at edge T, first out_valid at edge T+9, last out_valid at edge T+16. First in_valid of a new frame is accepted from the IDLE cycle after OUTPUT ends.
- Ignored inputs:
  - in_valid in START, SOLVE, CHECK and OUTPUT is ignored; no sample is stored.
  - core_done outside SOLVE is ignored.
- rd_cost is valid in every state; the solver must only rely on it from SOLVE onward.

Test Plan:
- Diagonal matrix (cost = 1 if w == j, else 50), core returns job[w] = w and cost 8 -> core_start pulses once; out_valid for 8 cycles from T+9; out_job = 1,2,...,8; out_cost = 8; err = 0.
- Same matrix, core reports cost 9 -> out_cost = 9 for all 8 beats; err = 1 from the last CHECK cycle through OUTPUT.
- Core returns job[w] = 0 for all w with cost = 8*50 - 49 -> err = 1 (duplicate); out_job = 1 eight times.
- 64 samples with in_valid low every other cycle, sample k = k mod 128 -> rd_row = 7, rd_col = 7 reads 63 and rd_row = 2, rd_col = 5 reads 21; core_start rises on the edge after the 64th store; extra in_valid pulses during SOLVE leave the buffer unchanged.
- TIMEOUT = 100, core_done never asserted -> err rises after 100 SOLVE cycles; then 8 beats with out_valid = 1, out_job = 0, out_cost = 0.
- All costs 127 with a valid permutation and cost 1016 -> out_cost = 1016, err = 0. Also: rst asserted mid-SOLVE -> next cycle core_start, out_valid and err are all 0; the following frame completes normally.
